// File: rtl/pool2_maxpool_pkg.sv
// rtl/pool2_maxpool_pkg.sv - shared cnn constants and pooling state encodings
// Contents: per-channel word width, channel count, layer-2 feature map
// dimensions and counter widths, and the pool2 row-phase state type.
package pool2_maxpool_pkg;

    localparam int BITS         = 16;
    localparam int BITS_SHIFT   = 4;
    localparam int CHANNEL_NUM  = 8;

    localparam int L2_LENGTH_IN = 26;
    localparam int L2_HEIGHT_IN = 26;
    localparam int L2_LENGTH_2  = 5;
    localparam int L2_HEIGHT_2  = 5;

    // ST_TOP: even input row, ST_BOT: odd input row
    typedef enum logic {
        ST_TOP = 1'b0,
        ST_BOT = 1'b1
    } pool_state_t;

endpackage

// File: rtl/pool2_maxpool_lane.sv
// rtl/pool2_maxpool_lane.sv - one-channel signed two-input maximum
// Ports:
//   i_a, i_b : signed two's-complement operands, bits wide
//   o_max    : the larger operand (ties return i_a, which equals i_b)
module pool_max_lane #(
    parameter int bits = 16
) (
    input  logic [bits-1:0] i_a,
    input  logic [bits-1:0] i_b,
    output logic [bits-1:0] o_max
);

    assign o_max = ($signed(i_a) >= $signed(i_b)) ? i_a : i_b;

endmodule

// File: rtl/pool2_maxpool.sv
// rtl/pool2_maxpool.sv - 2x2 stride-2 signed max pooling over a raster pixel stream
// Ports:
//   clk_in     : clock
//   rst_n      : asynchronous active-low reset
//   valid_in   : one-cycle strobe per input pixel, raster order
//   data_in    : channel_num signed words, channel k at [k*bits +: bits]
//   data_out   : registered pooled pixel, held until the next start
//   start      : one-cycle strobe marking a new data_out
//   frame_done : one-cycle strobe coinciding with the last start of a frame
// Build option: define POOL2_RELU_EN to clamp negative output channels to zero.
module pool2_maxpool
    import pool2_maxpool_pkg::*;
#(
    parameter int bits        = BITS,
    parameter int bits_shift  = BITS_SHIFT,
    parameter int channel_num = CHANNEL_NUM,
    parameter int length_in   = L2_LENGTH_IN,
    parameter int height_in   = L2_HEIGHT_IN,
    parameter int length_2    = L2_LENGTH_2,
    parameter int height_2    = L2_HEIGHT_2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n,
    input  logic                                  valid_in,
    input  logic [(channel_num<<bits_shift)-1:0]  data_in,
    output logic [(channel_num<<bits_shift)-1:0]  data_out,
    output logic                                  start,
    output logic                                  frame_done
);

    localparam int W        = channel_num << bits_shift;
    localparam int LB_DEPTH = length_in / 2;
    localparam logic [length_2-1:0] COL_LAST = length_2'(length_in - 1);
    localparam logic [height_2-1:0] ROW_LAST = height_2'(height_in - 1);

    pool_state_t          r_state;
    pool_state_t          w_state_next;
    logic [length_2-1:0]  r_col;
    logic [height_2-1:0]  r_row;
    logic [W-1:0]         r_hmax;
    logic [W-1:0]         r_linebuf [LB_DEPTH];

    logic [length_2-2:0]  w_lb_idx;
    logic [W-1:0]         w_lb_rd;
    logic [W-1:0]         w_hmax_new;
    logic [W-1:0]         w_pool;
    logic [W-1:0]         w_out_next;
    logic                 w_last_col;
    logic                 w_last_row;
    logic                 w_lb_we;
    logic                 w_out_fire;

    assign w_last_col = (r_col == COL_LAST);
    assign w_last_row = (r_row == ROW_LAST);
    assign w_lb_idx   = r_col[length_2-1:1];
    assign w_lb_rd    = r_linebuf[w_lb_idx];

    // Stage 1: horizontal pair max (meaningful on odd columns).
    // Stage 2: fold in the top-row pair max saved in the line buffer.
    for (genvar k = 0; k < channel_num; k++) begin : g_lane
        pool_max_lane #(.bits(bits)) u_hmax (
            .i_a   (r_hmax[k*bits +: bits]),
            .i_b   (data_in[k*bits +: bits]),
            .o_max (w_hmax_new[k*bits +: bits])
        );
        pool_max_lane #(.bits(bits)) u_vmax (
            .i_a   (w_lb_rd[k*bits +: bits]),
            .i_b   (w_hmax_new[k*bits +: bits]),
            .o_max (w_pool[k*bits +: bits])
        );
    end

    always_comb begin
        w_out_next = w_pool;
`ifdef POOL2_RELU_EN
        for (int k = 0; k < channel_num; k++) begin
            if (w_pool[k*bits + bits - 1]) begin
                w_out_next[k*bits +: bits] = '0;
            end
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        w_lb_we      = 1'b0;
        w_out_fire   = 1'b0;
        if (valid_in) begin
            case (r_state)
                ST_TOP: begin
                    w_lb_we = r_col[0];
                    if (w_last_col) begin
                        w_state_next = ST_BOT;
                    end
                end
                ST_BOT: begin
                    w_out_fire = r_col[0];
                    if (w_last_col) begin
                        w_state_next = ST_TOP;
                    end
                end
                default: w_state_next = ST_TOP;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_TOP;
            r_col      <= '0;
            r_row      <= '0;
            r_hmax     <= '0;
            data_out   <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            start      <= w_out_fire;
            frame_done <= w_out_fire && w_last_col && w_last_row;
            if (w_out_fire) begin
                data_out <= w_out_next;
            end
            if (valid_in) begin
                // Even column opens a new pair; odd column closes it.
                r_hmax <= r_col[0] ? w_hmax_new : data_in;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + height_2'(1);
                end else begin
                    r_col <= r_col + length_2'(1);
                end
            end
        end
    end

    // Not reset: every entry is rewritten during the top row before use.
    always_ff @(posedge clk_in) begin
        if (w_lb_we) begin
            r_linebuf[w_lb_idx] <= w_hmax_new;
        end
    end

endmodule

// File: tb/tb_pool2_maxpool.sv
// tb/tb_pool2_maxpool.sv - self-checking bench for pool2_maxpool (4x4 and 26x26 instances)
module tb_pool2_maxpool;

    localparam int W = 128;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         v4, v26;
    logic [W-1:0] d4, d26;
    logic [W-1:0] o4, o26;
    logic         s4, s26, f4, f26;

    always #5 clk_in = ~clk_in;

    pool2_maxpool #(
        .length_in(4), .height_in(4), .length_2(2), .height_2(2)
    ) dut4 (
        .clk_in(clk_in), .rst_n(rst_n), .valid_in(v4), .data_in(d4),
        .data_out(o4), .start(s4), .frame_done(f4)
    );

    pool2_maxpool dut26 (
        .clk_in(clk_in), .rst_n(rst_n), .valid_in(v26), .data_in(d26),
        .data_out(o26), .start(s26), .frame_done(f26)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [W-1:0] relu(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x;
`ifdef POOL2_RELU_EN
        for (int k = 0; k < 8; k++) if (x[k*16+15]) y[k*16 +: 16] = '0;
`endif
        return y;
    endfunction

    // ---------------- 4x4 instance capture ----------------
    logic [W-1:0] q4_data[$];
    logic         q4_fd[$];
    int           f4_orphan = 0;
    logic [W-1:0] pix4 [16];

    always @(negedge clk_in) begin
        if (rst_n) begin
            if (s4) begin
                q4_data.push_back(o4);
                q4_fd.push_back(f4);
            end else if (f4) begin
                f4_orphan++;
            end
        end
    end

    task automatic run4();
        for (int p = 0; p < 16; p++) begin
            d4 = pix4[p];
            v4 = 1'b1;
            @(posedge clk_in); #1;
            v4 = 1'b0;
        end
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    // ---------------- 26x26 instance monitor ----------------
    logic [W-1:0] exp26_d[$];
    logic         exp26_f[$];
    bit           drv_oddodd = 1'b0;
    bit           m_prev = 1'b0, m_last_start = 1'b0;
    logic [W-1:0] m_last = '0, m_first = '0;
    int           m_starts, m_fd, m_first_at;
    int           m_timing_err, m_adj_err, m_stab_err, m_data_err, m_fd_err;

    task automatic clear_mon(input int first_at);
        m_starts = 0; m_fd = 0; m_first_at = first_at; m_first = '0;
        m_timing_err = 0; m_adj_err = 0; m_stab_err = 0; m_data_err = 0; m_fd_err = 0;
    endtask

    always @(negedge clk_in) begin
        if (!rst_n) begin
            m_prev = 1'b0;
            m_last_start = 1'b0;
            m_last = o26;
        end else begin
            if (s26 !== m_prev) m_timing_err++;
            if (s26 && m_last_start) m_adj_err++;
            if (!s26 && o26 !== m_last) m_stab_err++;
            if (s26) begin
                if (m_starts == m_first_at) m_first = o26;
                m_starts++;
                if (f26) m_fd++;
                if (exp26_d.size() == 0) begin
                    m_data_err++;
                end else begin
                    if (o26 !== exp26_d.pop_front()) m_data_err++;
                    if (f26 !== exp26_f.pop_front()) m_fd_err++;
                end
            end else if (f26) begin
                m_fd_err++;
            end
            m_last       = o26;
            m_last_start = s26;
            m_prev       = v26 && drv_oddodd;
        end
    end

    // gap_mode < 0: random 0..5 idle cycles after each pixel, else fixed gap.
    task automatic run26(input int npix, input int gap_mode, output logic [W-1:0] first_exp);
        logic [W-1:0] fr [26][26];
        logic [W-1:0] m;
        bit           got_first;
        int           r, c, gap;
        got_first = 1'b0;
        first_exp = '0;
        for (int i = 0; i < 26; i++)
            for (int j = 0; j < 26; j++)
                fr[i][j] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 13; i++) begin
            for (int j = 0; j < 13; j++) begin
                if ((2*i+1)*26 + 2*j + 1 < npix) begin
                    for (int k = 0; k < 8; k++)
                        m[k*16 +: 16] = smax(smax(fr[2*i][2*j][k*16 +: 16],   fr[2*i][2*j+1][k*16 +: 16]),
                                             smax(fr[2*i+1][2*j][k*16 +: 16], fr[2*i+1][2*j+1][k*16 +: 16]));
                    m = relu(m);
                    exp26_d.push_back(m);
                    exp26_f.push_back(i == 12 && j == 12);
                    if (!got_first) begin
                        first_exp = m;
                        got_first = 1'b1;
                    end
                end
            end
        end
        for (int p = 0; p < npix; p++) begin
            r = p / 26;
            c = p % 26;
            d26 = fr[r][c];
            v26 = 1'b1;
            drv_oddodd = (r % 2 == 1) && (c % 2 == 1);
            @(posedge clk_in); #1;
            v26 = 1'b0;
            drv_oddodd = 1'b0;
            d26 = {$urandom, $urandom, $urandom, $urandom};
            gap = (gap_mode < 0) ? int'($urandom_range(0, 5)) : gap_mode;
            repeat (gap) begin
                @(posedge clk_in); #1;
            end
        end
    endtask

    task automatic check26(input string tag, input int starts, input int fds);
        check({tag, " starts"},     W'(m_starts),     W'(starts));
        check({tag, " frame_done"}, W'(m_fd),         W'(fds));
        check({tag, " data"},       W'(m_data_err),   W'(0));
        check({tag, " fd_pos"},     W'(m_fd_err),     W'(0));
        check({tag, " timing"},     W'(m_timing_err), W'(0));
        check({tag, " adjacent"},   W'(m_adj_err),    W'(0));
        check({tag, " stable"},     W'(m_stab_err),   W'(0));
        check({tag, " drained"},    W'(exp26_d.size()), W'(0));
    endtask

    // ---------------- table of 2x2 windows ----------------
    typedef struct packed {
        logic [3:0][15:0] c0;
        logic [3:0][15:0] c7;
        logic [15:0]      e0;
        logic [15:0]      e7;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [15:0] a3,
                                input logic [15:0] b0, input logic [15:0] b1,
                                input logic [15:0] b2, input logic [15:0] b3,
                                input logic [15:0] e0, input logic [15:0] e7);
        vec_t v;
        v.c0[0] = a0; v.c0[1] = a1; v.c0[2] = a2; v.c0[3] = a3;
        v.c7[0] = b0; v.c7[1] = b1; v.c7[2] = b2; v.c7[3] = b3;
        v.e0 = e0; v.e7 = e7;
        return v;
    endfunction

    vec_t tbl [8];
    logic [W-1:0] fx;
    logic [W-1:0] ramp_exp [4];

    initial begin
        tbl[0] = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A, 16'h0009, 16'h0008, 16'h0007, 16'h0004, 16'h000A);
        tbl[1] = mk(16'hFFFD, 16'hFFFF, 16'hFFF8, 16'hFFFE, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'hFFFF, 16'h0005);
        tbl[2] = mk(16'h0064, 16'hFF9C, 16'h0032, 16'h0063, 16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFFC, 16'h0064, 16'hFFFC);
        tbl[3] = mk(16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000);
        tbl[4] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
        tbl[5] = mk(16'h0003, 16'h0007, 16'h0007, 16'h0002, 16'hFFFE, 16'hFFFE, 16'h0001, 16'hFFFE, 16'h0007, 16'h0001);
        tbl[6] = mk(16'h8000, 16'h8001, 16'hFFFE, 16'h8AD0, 16'h000C, 16'h0022, 16'h0038, 16'h004E, 16'hFFFE, 16'h004E);
        tbl[7] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h1234, 16'h4321, 16'h0FFF, 16'h4320, 16'h0001, 16'h4321);

        ramp_exp[0] = W'(5);
        ramp_exp[1] = W'(7);
        ramp_exp[2] = W'(13);
        ramp_exp[3] = W'(15);

        rst_n = 1'b0;
        v4 = 1'b0; v26 = 1'b0; d4 = '0; d26 = '0;
        clear_mon(0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        @(posedge clk_in); #1;

        // Reset state
        check("rst data_out4",   o4,  '0);
        check("rst start4",      W'(s4),  W'(0));
        check("rst frame_done4", W'(f4),  W'(0));
        check("rst data_out26",  o26, '0);
        check("rst start26",     W'(s26), W'(0));
        check("rst frame_done26", W'(f26), W'(0));

        // 4x4 ramp on channel 0
        for (int p = 0; p < 16; p++) pix4[p] = W'(p);
        q4_data.delete(); q4_fd.delete();
        run4();
        check("ramp count", W'(q4_data.size()), W'(4));
        for (int i = 0; i < 4 && i < q4_data.size(); i++) begin
            check($sformatf("ramp out%0d", i), q4_data[i], ramp_exp[i]);
            check($sformatf("ramp fd%0d", i),  W'(q4_fd[i]), W'(i == 3));
        end

        // Table-driven windows, four per 4x4 frame
        for (int f = 0; f < 2; f++) begin
            for (int q = 0; q < 4; q++) begin
                for (int idx = 0; idx < 4; idx++) begin
                    pix4[(2*(q/2) + idx/2)*4 + 2*(q%2) + idx%2] =
                        {tbl[f*4+q].c7[idx], 96'b0, tbl[f*4+q].c0[idx]};
                end
            end
            q4_data.delete(); q4_fd.delete();
            run4();
            check($sformatf("tbl frame%0d count", f), W'(q4_data.size()), W'(4));
            for (int q = 0; q < 4 && q < q4_data.size(); q++) begin
                check($sformatf("tbl vec%0d", f*4+q), q4_data[q],
                      relu({tbl[f*4+q].e7, 96'b0, tbl[f*4+q].e0}));
            end
            check($sformatf("tbl frame%0d fd", f), W'(q4_fd.size() == 4 && q4_fd[3] && !q4_fd[0]), W'(1));
        end
        check("orphan frame_done4", W'(f4_orphan), W'(0));

        // Full 26x26 frame, valid every other cycle
        clear_mon(0);
        run26(676, 1, fx);
        repeat (4) @(posedge clk_in);
        #1;
        check26("alt", 169, 1);

        // Random gaps of 0..5 cycles
        clear_mon(0);
        run26(676, -1, fx);
        repeat (4) @(posedge clk_in);
        #1;
        check26("gaps", 169, 1);

        // Reset after 30 pixels, then a fresh frame
        clear_mon(0);
        run26(30, 0, fx);
        repeat (3) @(posedge clk_in);
        #1;
        check("partial starts", W'(m_starts), W'(2));
        rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        exp26_d.delete(); exp26_f.delete();
        clear_mon(0);
        run26(676, 1, fx);
        repeat (4) @(posedge clk_in);
        #1;
        check("post-reset first", m_first, fx);
        check26("fresh", 169, 1);

        // Two back-to-back frames with no idle cycle
        clear_mon(169);
        run26(676, 0, fx);
        run26(676, 0, fx);
        repeat (4) @(posedge clk_in);
        #1;
        check("b2b second first", m_first, fx);
        check26("b2b", 338, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
